// File: rtl/button_event_arbiter.sv
// Four-button debouncer with per-channel one-deep event slots and a round-robin
// valid/ready event port. Overwritten undelivered events raise a sticky overflow flag.
module button_event_arbiter #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_chan,
  output logic       evt_press,
  output logic [3:0] btn_state,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  logic [3:0]    r_s0;
  logic [3:0]    r_s1;
  logic [3:0]    r_btn_state;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_edge;
  logic [3:0]    r_pend;
  logic [3:0]    r_dir;
  logic [1:0]    r_last;
  logic [1:0]    r_chan;
  logic          r_press;
  logic          r_ovf;
  state_t        r_state;

  logic [CW-1:0] w_cnt_next [4];
  logic [3:0]    w_differ;
  logic [3:0]    w_load;
  logic [3:0]    w_pend_next;
  logic [3:0]    w_dir_next;
  logic [3:0]    w_ovw;
  logic [3:0]    w_grant_hit;
  logic [1:0]    w_rr_idx [4];
  logic          w_found;
  logic [1:0]    w_sel;
  logic          w_grant;
  state_t        w_state_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign w_differ[gi]   = r_s1[gi] ^ r_btn_state[gi];
      assign w_load[gi]     = w_differ[gi] && (r_cnt[gi] == CNT_LAST);
      assign w_cnt_next[gi] = (!w_differ[gi] || w_load[gi]) ? '0 : r_cnt[gi] + 1'b1;

      // A grant and a fresh edge in the same cycle: the old direction is
      // delivered and the new one stays pending, without overflow.
      assign w_grant_hit[gi] = w_grant && (w_sel == 2'(gi));
      assign w_pend_next[gi] = r_edge[gi] ? 1'b1 : (w_grant_hit[gi] ? 1'b0 : r_pend[gi]);
      assign w_dir_next[gi]  = r_edge[gi] ? r_btn_state[gi] : r_dir[gi];
      assign w_ovw[gi]       = r_edge[gi] && r_pend[gi] && !w_grant_hit[gi];

      assign w_rr_idx[gi] = r_last + 2'(gi + 1);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0        <= '0;
      r_s1        <= '0;
      r_btn_state <= '0;
      r_edge      <= '0;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      r_s0        <= btn_in;
      r_s1        <= r_s0;
      r_btn_state <= r_btn_state ^ w_load;
      r_edge      <= w_load;
      for (int k = 0; k < 4; k++) r_cnt[k] <= w_cnt_next[k];
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && r_pend[w_rr_idx[k]]) begin
        w_found = 1'b1;
        w_sel   = w_rr_idx[k];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant      = 1'b1;
          w_state_next = S_OFFER;
        end
      end
      S_OFFER: begin
        if (evt_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_dir   <= '0;
      r_last  <= 2'd3;
      r_chan  <= '0;
      r_press <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_dir   <= w_dir_next;
      if (w_grant) begin
        r_chan  <= w_sel;
        r_press <= r_dir[w_sel];
        r_last  <= w_sel;
      end
      if (|w_ovw)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign evt_valid = (r_state == S_OFFER);
  assign evt_chan  = r_chan;
  assign evt_press = r_press;
  assign btn_state = r_btn_state;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: sample-window debounce model plus slot/round-robin
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_button_event_arbiter;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_chan;
  logic       evt_press;
  logic [3:0] btn_state;
  logic       overflow;
  logic       ovf_clr;

  button_event_arbiter #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_press (evt_press),
    .btn_state (btn_state),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // h[k] = btn_in sampled k edges ago; the synchronized view lags by two edges,
  // and a level is accepted once the last D synchronized samples all disagree
  // with the current debounced state.
  logic [3:0] h [0:D+1];
  logic [3:0] m_state, m_pend, m_dir, m_flip_prev, m_flip;
  bit         m_off, m_press, m_ovf;
  int         m_chan, m_last, granted;
  int         m_log_chan[$], m_log_press[$];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= D + 1; k++) h[k] = '0;
      m_state = '0; m_pend = '0; m_dir = '0; m_flip_prev = '0;
      m_off = 0; m_chan = 0; m_press = 0; m_last = 3; m_ovf = 0;
    end else begin
      for (int k = D + 1; k > 0; k--) h[k] = h[k-1];
      h[0] = btn_in;

      granted = -1;
      if (m_off) begin
        if (evt_ready) begin
          m_log_chan.push_back(m_chan);
          m_log_press.push_back(int'(m_press));
          m_off = 0;
        end
      end else if (m_pend != 0) begin
        for (int k = 1; k <= 4; k++)
          if (granted < 0 && m_pend[(m_last + k) % 4]) granted = (m_last + k) % 4;
        m_off = 1; m_chan = granted; m_press = m_dir[granted]; m_last = granted;
      end

      begin
        bit ovw;
        ovw = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_flip_prev[i]) begin
            if (m_pend[i] && granted != i) ovw = 1;
            m_pend[i] = 1'b1;
            m_dir[i]  = m_state[i];
          end else if (granted == i) begin
            m_pend[i] = 1'b0;
          end
        end
        if (ovw) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
      end

      for (int i = 0; i < 4; i++) begin
        m_flip[i] = 1'b1;
        for (int k = 2; k <= D + 1; k++)
          if (h[k][i] == m_state[i]) m_flip[i] = 1'b0;
      end
      m_state     = m_state ^ m_flip;
      m_flip_prev = m_flip;
    end
  end

  // ---------------- monitor: DUT transfer log + per-cycle compare ----------------
  int  dut_chan[$], dut_press[$], dut_cyc[$];
  bit  snap_v, snap_p;
  int  snap_c;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      snap_v = 0;
    end else begin
      if (snap_v && evt_ready) begin
        dut_chan.push_back(snap_c);
        dut_press.push_back(int'(snap_p));
        dut_cyc.push_back(cyc);
      end
      snap_v = evt_valid; snap_c = int'(evt_chan); snap_p = evt_press;
    end
    if (mon_en) begin
      chk("valid", 32'(evt_valid), 32'(m_off));
      if (m_off) begin
        chk("chan", 32'(evt_chan), 32'(m_chan));
        chk("press", 32'(evt_press), 32'(m_press));
      end
      chk("btn_state", 32'(btn_state), 32'(m_state));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic clear_logs();
    dut_chan.delete(); dut_press.delete(); dut_cyc.delete();
    m_log_chan.delete(); m_log_press.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; btn_in = '0; evt_ready = 0; ovf_clr = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    clear_logs();
  endtask

  initial begin
    bit seen, stable;
    rst = 1; btn_in = '0; evt_ready = 0; ovf_clr = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    mon_en = 1;

    // Raise btn_in[2]: state after 6 edges, offer after 8, drop after accept.
    do_reset();
    btn_in = 4'b0100;
    repeat (5) @(posedge clk);
    #1 chk("t31_state_early", 32'(btn_state[2]), 32'd0);
    @(posedge clk);
    #1 chk("t31_state", 32'(btn_state[2]), 32'd1);
    @(posedge clk);
    #1 chk("t31_valid_early", 32'(evt_valid), 32'd0);
    @(posedge clk);
    #1 chk("t31_valid", 32'(evt_valid), 32'd1);
    chk("t31_chan", 32'(evt_chan), 32'd2);
    chk("t31_press", 32'(evt_press), 32'd1);
    @(negedge clk) evt_ready = 1;
    @(posedge clk);
    #1 chk("t31_drop", 32'(evt_valid), 32'd0);
    @(negedge clk) evt_ready = 0;

    // Three-cycle glitch is rejected.
    do_reset();
    seen = 0;
    btn_in = 4'b0001;
    repeat (3) @(negedge clk);
    btn_in = 4'b0000;
    repeat (12) begin
      @(posedge clk);
      #1 if (btn_state != 0 || evt_valid) seen = 1;
    end
    chk("t32_glitch", 32'(seen), 32'd0);

    // Simultaneous presses on 0,1,3 with ready high: in order, every two cycles.
    do_reset();
    evt_ready = 1;
    btn_in = 4'b1011;
    repeat (20) @(negedge clk);
    evt_ready = 0;
    chk("t33_count", 32'(dut_chan.size()), 32'd3);
    chk("t33_model_count", 32'(m_log_chan.size()), 32'd3);
    if (dut_chan.size() == 3) begin
      chk("t33_ch0", 32'(dut_chan[0]), 32'd0);
      chk("t33_ch1", 32'(dut_chan[1]), 32'd1);
      chk("t33_ch2", 32'(dut_chan[2]), 32'd3);
      chk("t33_gap1", 32'(dut_cyc[1] - dut_cyc[0]), 32'd2);
      chk("t33_gap2", 32'(dut_cyc[2] - dut_cyc[1]), 32'd2);
      chk("t33_press", 32'(dut_press[0] + dut_press[1] + dut_press[2]), 32'd3);
    end
    if (m_log_chan.size() == 3) chk("t33_model_ch2", 32'(m_log_chan[2]), 32'd3);

    // Press+release ch1 while ch0 is stuck on the port: overflow, one release delivered.
    do_reset();
    btn_in = 4'b0001;
    repeat (10) @(negedge clk);
    chk("t34_offer0", 32'(evt_valid && evt_chan == 2'd0), 32'd1);
    btn_in = 4'b0011;
    repeat (8) @(negedge clk);
    chk("t34_no_ovf_yet", 32'(overflow), 32'd0);
    btn_in = 4'b0001;
    repeat (9) @(negedge clk);
    chk("t34_ovf", 32'(overflow), 32'd1);
    evt_ready = 1;
    repeat (6) @(negedge clk);
    evt_ready = 0;
    chk("t34_count", 32'(dut_chan.size()), 32'd2);
    chk("t34_model_count", 32'(m_log_chan.size()), 32'd2);
    if (dut_chan.size() == 2) begin
      chk("t34_first", 32'(dut_chan[0] * 2 + dut_press[0]), 32'd1);
      chk("t34_second", 32'(dut_chan[1] * 2 + dut_press[1]), 32'd2);
    end
    chk("t34_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1;
    @(negedge clk) ovf_clr = 0;
    chk("t34_ovf_clr", 32'(overflow), 32'd0);

    // Offer held 20 cycles without ready, then reset drops it with no replay.
    do_reset();
    btn_in = 4'b0100;
    repeat (10) @(negedge clk);
    stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (!(evt_valid && evt_chan == 2'd2 && evt_press)) stable = 0;
    end
    chk("t35_hold", 32'(stable), 32'd1);
    rst = 1; btn_in = 4'b0000;
    #1;
    chk("t35_rst_valid", 32'(evt_valid), 32'd0);
    chk("t35_rst_out", 32'({evt_chan, evt_press, btn_state, overflow}), 32'd0);
    @(negedge clk) rst = 0;
    clear_logs();
    evt_ready = 1;
    repeat (15) @(negedge clk);
    evt_ready = 0;
    chk("t35_no_replay", 32'(dut_chan.size()), 32'd0);

    // All buttons held through reset release: four presses 0,1,2,3.
    @(negedge clk);
    rst = 1; btn_in = 4'b1111; evt_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    clear_logs();
    repeat (20) @(negedge clk);
    evt_ready = 0;
    chk("t36_count", 32'(dut_chan.size()), 32'd4);
    if (dut_chan.size() == 4)
      for (int i = 0; i < 4; i++) chk("t36_order", 32'(dut_chan[i] * 2 + dut_press[i]), 32'(i * 2 + 1));
    if (m_log_chan.size() == 4) chk("t36_model_last", 32'(m_log_chan[3]), 32'd3);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 699) == 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) btn_in[i] = ~btn_in[i];
      evt_ready = ($urandom_range(0, 3) < ((n < 2000) ? 1 : 3));
      ovf_clr   = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    rst = 0; ovf_clr = 0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
